// File: rtl/micro_seq.sv
// Microprogram sequencer: owns the control-store address register and picks
// increment, jump, decode dispatch or return-stack pop each cycle, with memory-wait stall and halt.
module micro_seq #(
   parameter int DATAWIDTH_CSADDRESS = 11,
   parameter int DATAWIDTH_OPS       = 8,
   parameter int DATAWIDTH_CBL       = 2,
   parameter int STACK_DEPTH         = 4,
   parameter int WAIT_LIMIT          = 255,
   parameter int RESET_ADDRESS       = 0
) (
   input  logic                           MICRO_SEQ_CLOCK_50,
   input  logic                           MICRO_SEQ_ResetInLow_In,
   input  logic [2:0]                     MICRO_SEQ_Cond_InBus,
   input  logic [DATAWIDTH_CSADDRESS-1:0] MICRO_SEQ_JumpAddress_InBus,
   input  logic [DATAWIDTH_OPS-1:0]       MICRO_SEQ_DecodeOp_InBus,
   input  logic [3:0]                     MICRO_SEQ_Flags_InBus,
   input  logic                           MICRO_SEQ_IR13_In,
   input  logic                           MICRO_SEQ_Call_In,
   input  logic                           MICRO_SEQ_Ret_In,
   input  logic                           MICRO_SEQ_Wait_In,
   input  logic                           MICRO_SEQ_MemReady_In,
   output logic [DATAWIDTH_CSADDRESS-1:0] MICRO_SEQ_CSAddress_OutBus,
   output logic [DATAWIDTH_CBL-1:0]       MICRO_SEQ_Tipo_OutBus,
   output logic                           MICRO_SEQ_Stall_Out,
   output logic                           MICRO_SEQ_Halt_Out,
   output logic [1:0]                     MICRO_SEQ_Error_OutBus
);

   localparam int AW   = DATAWIDTH_CSADDRESS;
   localparam int SPW  = $clog2(STACK_DEPTH);
   localparam int SPCW = SPW + 1;
   localparam int CW   = $clog2(WAIT_LIMIT + 1);

   localparam logic [DATAWIDTH_CBL-1:0] TIPO_INC  = DATAWIDTH_CBL'(0);
   localparam logic [DATAWIDTH_CBL-1:0] TIPO_JMP  = DATAWIDTH_CBL'(1);
   localparam logic [DATAWIDTH_CBL-1:0] TIPO_DEC  = DATAWIDTH_CBL'(2);
   localparam logic [DATAWIDTH_CBL-1:0] TIPO_HOLD = DATAWIDTH_CBL'(3);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_WAIT,
      ST_HALT
   } state_t;

   state_t                   state_q, state_d;
   logic [AW-1:0]            addr_q, addr_d;
   logic [DATAWIDTH_CBL-1:0] tipo_q, tipo_d;
   logic [SPCW-1:0]          sp_q, sp_d;
   logic [AW-1:0]            stack_q [STACK_DEPTH];
   logic [AW-1:0]            stack_d [STACK_DEPTH];
   logic [CW-1:0]            wait_cnt_q, wait_cnt_d;
   logic [1:0]               err_q, err_d;

   logic [AW-1:0]   addr_inc;
   logic [AW-1:0]   decode_addr;
   logic [SPCW-1:0] sp_m1;
   logic            cond_true;
   logic            run_eval;

   assign addr_inc    = addr_q + AW'(1);
   assign decode_addr = AW'({1'b1, MICRO_SEQ_DecodeOp_InBus, 2'b00});
   assign sp_m1       = sp_q - SPCW'(1);

   always_comb begin
      cond_true = 1'b0;
      case (MICRO_SEQ_Cond_InBus)
         3'b001:  cond_true = MICRO_SEQ_Flags_InBus[3];
         3'b010:  cond_true = MICRO_SEQ_Flags_InBus[2];
         3'b011:  cond_true = MICRO_SEQ_Flags_InBus[1];
         3'b100:  cond_true = MICRO_SEQ_Flags_InBus[0];
         3'b101:  cond_true = MICRO_SEQ_IR13_In;
         3'b110:  cond_true = 1'b1;
         default: cond_true = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      tipo_d     = tipo_q;
      sp_d       = sp_q;
      stack_d    = stack_q;
      wait_cnt_d = wait_cnt_q;
      err_d      = err_q;
      run_eval   = 1'b0;

      case (state_q)
         ST_RUN: run_eval = 1'b1;
         ST_WAIT: begin
            if (MICRO_SEQ_MemReady_In) begin
               wait_cnt_d = '0;
               run_eval   = 1'b1;
            end else if (wait_cnt_q == CW'(WAIT_LIMIT - 1)) begin
               state_d    = ST_HALT;
               tipo_d     = TIPO_HOLD;
               err_d[1]   = 1'b1;
               wait_cnt_d = CW'(WAIT_LIMIT);
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         ST_HALT: tipo_d = TIPO_HOLD;
         default: begin
            state_d = ST_HALT;
            tipo_d  = TIPO_HOLD;
         end
      endcase

      // Shared RUN decision; a WAIT that just saw MemReady resolves here on the same edge.
      if (run_eval) begin
         state_d = ST_RUN;
         if (MICRO_SEQ_Wait_In && !MICRO_SEQ_MemReady_In) begin
            state_d    = ST_WAIT;
            tipo_d     = TIPO_HOLD;
            wait_cnt_d = '0;
         end else if (MICRO_SEQ_Call_In && MICRO_SEQ_Ret_In) begin
            state_d  = ST_HALT;
            tipo_d   = TIPO_HOLD;
            err_d[0] = 1'b1;
         end else if (MICRO_SEQ_Call_In) begin
            if (sp_q == SPCW'(STACK_DEPTH)) begin
               state_d  = ST_HALT;
               tipo_d   = TIPO_HOLD;
               err_d[0] = 1'b1;
            end else begin
               stack_d[sp_q[SPW-1:0]] = addr_inc;
               sp_d   = sp_q + SPCW'(1);
               addr_d = MICRO_SEQ_JumpAddress_InBus;
               tipo_d = TIPO_JMP;
            end
         end else if (MICRO_SEQ_Ret_In) begin
            if (sp_q == '0) begin
               state_d  = ST_HALT;
               tipo_d   = TIPO_HOLD;
               err_d[0] = 1'b1;
            end else begin
               addr_d = stack_q[sp_m1[SPW-1:0]];
               sp_d   = sp_m1;
               tipo_d = TIPO_HOLD;
            end
         end else if (MICRO_SEQ_Cond_InBus == 3'b111) begin
            addr_d = decode_addr;
            tipo_d = TIPO_DEC;
         end else if (cond_true) begin
            addr_d = MICRO_SEQ_JumpAddress_InBus;
            tipo_d = TIPO_JMP;
         end else begin
            addr_d = addr_inc;
            tipo_d = TIPO_INC;
         end
      end
   end

   always_ff @(posedge MICRO_SEQ_CLOCK_50 or negedge MICRO_SEQ_ResetInLow_In) begin
      if (!MICRO_SEQ_ResetInLow_In) begin
         state_q    <= ST_RUN;
         addr_q     <= AW'(RESET_ADDRESS);
         tipo_q     <= TIPO_INC;
         sp_q       <= '0;
         wait_cnt_q <= '0;
         err_q      <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         tipo_q     <= tipo_d;
         sp_q       <= sp_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
         end
      end
   end

   assign MICRO_SEQ_CSAddress_OutBus = addr_q;
   assign MICRO_SEQ_Tipo_OutBus      = tipo_q;
   assign MICRO_SEQ_Stall_Out        = (state_q == ST_WAIT);
   assign MICRO_SEQ_Halt_Out         = (state_q == ST_HALT);
   assign MICRO_SEQ_Error_OutBus     = err_q;

endmodule

// File: doc/micro_seq.md
# micro_seq

Microprogram sequencer for the microcoded datapath. Owns the control-store address register and decides each cycle, from the current microword's branch field, the condition codes and the decoded opcode, which address is presented next: increment, jump, or opcode dispatch. It also drives the select code that steers the control-store address mux. It adds a small micro-subroutine return stack, a memory-wait stall with watchdog, and a halt-on-error state.

## Interface
Parameters:
- DATAWIDTH_CSADDRESS, 11, control-store address width
- DATAWIDTH_OPS, 8, decode opcode width: op[7:6], op3[5:0]
- DATAWIDTH_CBL, 2, mux select width
- STACK_DEPTH, 4, return-stack entries
- WAIT_LIMIT, 255, maximum consecutive stall cycles before halt
- RESET_ADDRESS, 0, address after reset

Ports:
- MICRO_SEQ_CLOCK_50  in  1  single clock, rising edge
- MICRO_SEQ_ResetInLow_In  in  1  asynchronous, active-low reset
- MICRO_SEQ_Cond_InBus  in  3  branch field: 000 next, 001 N, 010 Z, 011 V, 100 C, 101 IR13, 110 always, 111 decode
- MICRO_SEQ_JumpAddress_InBus  in  11  microword jump target
- MICRO_SEQ_DecodeOp_InBus  in  8  opcode from instruction register
- MICRO_SEQ_Flags_InBus  in  4  {N,Z,V,C}
- MICRO_SEQ_IR13_In  in  1  instruction bit 13
- MICRO_SEQ_Call_In  in  1  push return address, jump to target
- MICRO_SEQ_Ret_In  in  1  pop and jump to popped address
- MICRO_SEQ_Wait_In  in  1  microword waits on memory
- MICRO_SEQ_MemReady_In  in  1  memory done
- MICRO_SEQ_CSAddress_OutBus  out  11  registered control-store address
- MICRO_SEQ_Tipo_OutBus  out  2  mux select: 00 increment, 01 jump, 10 decode, 11 hold/stack
- MICRO_SEQ_Stall_Out  out  1  high while in WAIT
- MICRO_SEQ_Halt_Out  out  1  high in HALT
- MICRO_SEQ_Error_OutBus  out  2  sticky: [0] stack over/underflow or Call+Ret, [1] wait timeout

## Operation
- States: RUN, WAIT, HALT. Reset puts the block in RUN.
- Reset values: address = RESET_ADDRESS, stack pointer 0, wait counter 0, Tipo 00, Stall 0, Halt 0, Error 00.
- In RUN, when Wait_In=1 and MemReady_In=0:
  - Go to WAIT and hold the address (Tipo 11).
  - No push or pop occurs.
- In RUN otherwise, take the first matching rule:
  - Call_In and Ret_In both 1 → HALT, Error[0] set.
  - Call_In=1 → push address+1, next address = JumpAddress (Tipo 01). Stack already full → HALT, Error[0] set, no push.
  - Ret_In=1 → next address = top of stack, pop (Tipo 11). Stack empty → HALT, Error[0] set.
  - Cond 111 → next address = {1, op[7:6], op3[5:0], 00} (Tipo 10).
  - Cond 110 → jump (Tipo 01).
  - Cond 001–101 → jump if the selected condition is 1, else address+1.
  - Cond 000 → address+1 (Tipo 00).
- Increment is modulo 2^11: 0x7FF+1 = 0x000. Overflow is not an error.
- WAIT:
  - The counter increments each cycle.
  - When MemReady_In=1: clear the counter, return to RUN, and evaluate the RUN decision on that same edge using the current inputs.
  - When the counter reaches WAIT_LIMIT with MemReady still 0: HALT, Error[1] set.
- HALT:
  - Address frozen, Tipo 11, Halt 1.
  - Left only by reset.
  - Error bits are sticky until reset.

## Timing
- Next-address logic is combinational from the current inputs. The address register loads on the rising edge, giving 1-cycle latency from microword fields to the new address.
- Push and pop occur on the same edge as the address update. A Ret in the cycle immediately after a Call returns address_of_call+1.
- Stall_Out, Halt_Out and Error are registered. They assert on the edge that enters the state.
- Reset asserted mid-WAIT or mid-call clears everything asynchronously. The first rising edge after release evaluates from RESET_ADDRESS.
- MemReady_In=1 while Wait_In=1 in RUN does not stall; the address advances normally.

## Test plan
- Reset, Cond 000 for 3 cycles → addresses 0, 1, 2, 3. At 0x7FF with Cond 000 → 0x000.
- Cond 010, Z=1, Jump 0x123 → address 0x123, Tipo 01. Then Z=0 → 0x124, Tipo 00.
- Cond 111, DecodeOp 0x9A (op=10, op3=011010) → address 0x668, Tipo 10.
- At 0x010, Call to 0x200; then Ret → 0x200, then 0x011. Five nested Calls with STACK_DEPTH=4 → HALT, Error=01, address frozen.
- Wait_In=1 with MemReady low for 3 cycles, then high with Cond 000 at 0x040 → address held at 0x040 for 3 cycles with Stall=1, then 0x041. MemReady held low for WAIT_LIMIT cycles → HALT, Error=10.
- Assert reset while in WAIT and while in HALT → address 0, all flags 0, stack empty; normal stepping resumes after release.
